fmeasure_scheduler: RTL and testbench
=====================================

// Module: fmeasure_scheduler
// PURPOSE
//  Shares one frequency-measurement engine (start/busy/ca/cb handshake, 32-bit counts) among N_CH
//  input channels. Latches per-channel requests, grants them round-robin and steers the engine's
//  wave mux. Sequences settle/start/busy, captures ca/cb into a per-channel result bank and
//  signals completion per channel.
// PARAMETERS
//  N_CH        4     number of channels (2..16)
//  SETTLE_CYC  4     clk cycles waited after wave_sel changes before start (>=1)
//  TIMEOUT_CYC 2**24 watchdog limit on a measurement, clk cycles (used only with FMSCHED_TIMEOUT_EN)
// PORTS
//  clk        in   1                 system clock, all logic posedge
//  rst        in   1                 asynchronous, active-high reset
//  req        in   N_CH              1-cycle pulse per channel: request a measurement
//  done       out  N_CH              1-cycle pulse: channel result updated
//  err        out  N_CH              1-cycle pulse: channel measurement aborted (timeout)
//  idle       out  1                 high when FSM in IDLE and no request pending
//  wave_sel   out  $clog2(N_CH)      engine wave mux select, held stable from SETTLE to STORE
//  meas_start out  1                 1-cycle start pulse to engine
//  meas_busy  in   1                 engine busy
//  meas_ca    in   32                engine count A, valid when busy falls
//  meas_cb    in   32                engine count B, valid when busy falls
//  meas_abort out  1                 1-cycle pulse: parent resets engine (tied 0 without macro)
//  rd_ch      in   $clog2(N_CH)      result read address
//  rd_ca      out  32                stored ca of rd_ch (combinational read)
//  rd_cb      out  32                stored cb of rd_ch
//  rd_valid   out  1                 rd_ch holds a completed result
// BEHAVIOUR
//  - Reset: FSM=IDLE, pending=0, ptr=N_CH-1, wave_sel=0, all pulses 0, results=0, valid=0.
//  - pending[i] set by req[i]; cleared at ISSUE of channel i. Same-cycle set and clear: set wins.
//  - Arbitration: grant = first pending index strictly after ptr, wrapping modulo N_CH. ptr <= grant
//    at ISSUE. Fixed-priority is forbidden; every pending channel is served within N_CH grants.
//  - FSM states, one transition per clk:
//    IDLE   -> SETTLE when any pending: wave_sel <= grant, cnt <= 0.
//    SETTLE -> ISSUE after SETTLE_CYC cycles in SETTLE.
//    ISSUE  -> ACK: meas_start=1 for exactly this cycle; pending[grant] cleared.
//    ACK    -> RUN on first cycle meas_busy=1.
//    RUN    -> STORE on first cycle meas_busy=0: register meas_ca/meas_cb into bank[wave_sel].
//    STORE  -> IDLE: valid[wave_sel] <= 1, done[wave_sel] pulses this cycle.
//  - Latency: req to meas_start = 1 + SETTLE_CYC + 1 cycles when idle. Back-to-back grants pass through
//    IDLE for one cycle.
//  - rd_* reflect the bank combinationally. A same-cycle write and read returns the old value.
//  - Counts stored unmodified (32-bit unsigned); no arithmetic performed.
//  - Mid-operation reset: immediate return to reset values. Engine is reset by its own reset.
// CONFIGURATION
//  FMSCHED_TIMEOUT_EN defined: watchdog counts cycles in ACK+RUN. On reaching TIMEOUT_CYC:
//    meas_abort=1 and err[wave_sel]=1 for one cycle, valid[wave_sel] <= 0, bank unchanged,
//    FSM -> IDLE. Channel not re-queued.
//  FMSCHED_TIMEOUT_EN undefined: no watchdog logic, meas_abort=0, err=0; FSM waits indefinitely.
// STRUCTURE
//  fmsched_pkg: state_t enum (IDLE, SETTLE, ISSUE, ACK, RUN, STORE), COUNT_W=32 constant,
//    clog2-based select-width function.
//  Sub-module fmsched_rr_arb: pending vector + ptr in, grant index + any_valid out, purely
//    combinational. FSM, bank and watchdog stay in fmeasure_scheduler.
// TESTING (N_CH=4, SETTLE_CYC=2, TIMEOUT_CYC=1000, behavioural engine model)
//  1 Single req[2] -> wave_sel=2, meas_start 4 cycles later; engine returns ca=1000, cb=250 ->
//    done[2] pulse, rd_ch=2 gives 1000/250, rd_valid=1.
//  2 req=4'b1111 in one cycle with ptr=3 -> service order 0,1,2,3; done pulses in that order; idle=1 after.
//  3 req[1] re-pulsed on the cycle ch1 is in ISSUE -> ch1 measured twice, second result overwrites first.
//  4 rst asserted during RUN -> next cycle FSM IDLE, meas_start=0, rd_valid=0 for all, no done pulse.
//  5 (macro on) engine never drops busy -> meas_abort and err[ch] pulse at cycle 1000 of ACK+RUN,
//    rd_valid=0; queued ch continues. (macro off) FSM still in RUN after 5000 cycles, err=0.
//  6 wave_sel checked constant from SETTLE entry through STORE on every measurement.

Source files
------------

// File: rtl/fmsched_pkg.sv
// Shared types and helpers for the frequency-measurement scheduler.
package fmsched_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ISSUE  = 3'd2,
    ACK    = 3'd3,
    RUN    = 3'd4,
    STORE  = 3'd5
  } state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmeasure_scheduler_if.sv
// Handshake between the scheduler (master) and the shared measurement engine (slave).
interface fmeasure_scheduler_if #(
  parameter int N_CH = 4
);
  import fmsched_pkg::*;

  localparam int SEL_W = sel_width(N_CH);

  logic [SEL_W-1:0]   wave_sel;
  logic               meas_start;
  logic               meas_busy;
  logic               meas_abort;
  logic [COUNT_W-1:0] meas_ca;
  logic [COUNT_W-1:0] meas_cb;

  modport master (
    output wave_sel, meas_start, meas_abort,
    input  meas_busy, meas_ca, meas_cb
  );

  modport slave (
    input  wave_sel, meas_start, meas_abort,
    output meas_busy, meas_ca, meas_cb
  );

endinterface

// File: rtl/fmsched_rr_arb.sv
// Round-robin pick: first pending channel strictly after ptr, wrapping.
module fmsched_rr_arb
  import fmsched_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]            pending,
  input  logic [sel_width(N_CH)-1:0] ptr,
  output logic [sel_width(N_CH)-1:0] grant,
  output logic                       any_valid
);

  localparam int SEL_W = sel_width(N_CH);

  // Scan from farthest to nearest so the nearest pending channel after ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_valid = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_CH;
      if (pending[idx]) begin
        grant     = SEL_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmeasure_scheduler.sv
// Shares one frequency-measurement engine among N_CH channels.
// Optional watchdog enabled by defining FMSCHED_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | waiting for a pending channel
//  SETTLE | wave mux switched, waiting SETTLE_CYC cycles
//  ISSUE  | meas_start pulse, request consumed
//  ACK    | waiting for the engine to raise busy
//  RUN    | engine measuring, waiting for busy to fall
//  STORE  | result written, done pulse
module fmeasure_scheduler
  import fmsched_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  output logic [N_CH-1:0]            done,
  output logic [N_CH-1:0]            err,
  output logic                       idle,
  fmeasure_scheduler_if.master       eng,
  input  logic [sel_width(N_CH)-1:0] rd_ch,
  output logic [COUNT_W-1:0]         rd_ca,
  output logic [COUNT_W-1:0]         rd_cb,
  output logic                       rd_valid
);

  localparam int SEL_W = sel_width(N_CH);
  localparam int CNT_W = $clog2(SETTLE_CYC) + 1;

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_SETTLE = 3'(SETTLE);
  localparam logic [2:0] ST_ISSUE  = 3'(ISSUE);
  localparam logic [2:0] ST_ACK    = 3'(ACK);
  localparam logic [2:0] ST_RUN    = 3'(RUN);
  localparam logic [2:0] ST_STORE  = 3'(STORE);

  if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
    $error("fmeasure_scheduler: N_CH must be 2..16");
  end
  if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cyc
    $error("fmeasure_scheduler: SETTLE_CYC and TIMEOUT_CYC must be >= 1");
  end

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [N_CH-1:0]    pending;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   wave_sel;
  logic [SEL_W-1:0]   grant;
  logic               any_valid;
  logic [N_CH-1:0]    sel_oh;
  logic [N_CH-1:0]    valid;
  logic [COUNT_W-1:0] bank_ca [N_CH];
  logic [COUNT_W-1:0] bank_cb [N_CH];
  logic               to_hit;

  fmsched_rr_arb #(.N_CH(N_CH)) u_arb (
    .pending   (pending),
    .ptr       (ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign sel_oh = N_CH'(1) << wave_sel;

`ifdef FMSCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] wd;

  // Watchdog counts every cycle spent waiting on the engine (ACK + RUN).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd <= '0;
    else if (state == ST_ACK || state == ST_RUN)
      wd <= wd + 1'b1;
    else
      wd <= '0;
  end

  assign to_hit = (state == ST_ACK || state == ST_RUN) && (wd == WD_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Request latch: a new request in the same cycle as its issue survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= (pending & ~((state == ST_ISSUE) ? sel_oh : '0)) | req;
  end

  // Sequencer: settle, start, wait for busy to rise and fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= SEL_W'(N_CH - 1);
      wave_sel <= '0;
    end else if (to_hit) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (any_valid) begin
          state    <= ST_SETTLE;
          wave_sel <= grant;
          cnt      <= '0;
        end
        ST_SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state <= ST_ISSUE;
                   else cnt <= cnt + 1'b1;
        ST_ISSUE: begin
          state <= ST_ACK;
          ptr   <= wave_sel;
        end
        ST_ACK:   if (eng.meas_busy) state <= ST_RUN;
        ST_RUN:   if (!eng.meas_busy) state <= ST_STORE;
        ST_STORE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Result bank: counts captured as the engine drops busy; a timeout leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        bank_ca[i] <= '0;
        bank_cb[i] <= '0;
      end
    end else if (state == ST_RUN && !eng.meas_busy && !to_hit) begin
      bank_ca[wave_sel] <= eng.meas_ca;
      bank_cb[wave_sel] <= eng.meas_cb;
    end
  end

  // Validity: set on completion, cleared when the measurement is aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid <= '0;
    else if (to_hit)
      valid[wave_sel] <= 1'b0;
    else if (state == ST_STORE)
      valid[wave_sel] <= 1'b1;
  end

  assign eng.wave_sel   = wave_sel;
  assign eng.meas_start = (state == ST_ISSUE);
  assign eng.meas_abort = to_hit;
  assign done           = (state == ST_STORE) ? sel_oh : '0;
  assign err            = to_hit ? sel_oh : '0;
  assign idle           = (state == ST_IDLE) && (pending == '0);

  assign rd_ca    = (int'(rd_ch) < N_CH) ? bank_ca[rd_ch] : '0;
  assign rd_cb    = (int'(rd_ch) < N_CH) ? bank_cb[rd_ch] : '0;
  assign rd_valid = (int'(rd_ch) < N_CH) ? valid[rd_ch] : 1'b0;

endmodule

// File: tb/tb_fmeasure_scheduler.sv
// Scoreboard bench for fmeasure_scheduler with a behavioural measurement engine.
module tb_fmeasure_scheduler;

  localparam int N_CH = 4;
  localparam int SETTLE_CYC = 2;
  localparam int TIMEOUT_CYC = 1000;

  typedef struct {
    int          ch;
    logic [31:0] ca;
    logic [31:0] cb;
    bit          hang;
  } exp_t;

  typedef struct {
    logic [31:0] ca;
    logic [31:0] cb;
    int          lat;
    bit          hang;
  } eng_t;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] done;
  logic [N_CH-1:0] err;
  logic            idle;
  logic [1:0]      rd_ch;
  logic [31:0]     rd_ca;
  logic [31:0]     rd_cb;
  logic            rd_valid;

  fmeasure_scheduler_if #(.N_CH(N_CH)) eng_if ();

  fmeasure_scheduler #(
    .N_CH(N_CH), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .err(err), .idle(idle),
    .eng(eng_if), .rd_ch(rd_ch), .rd_ca(rd_ca), .rd_cb(rd_cb), .rd_valid(rd_valid)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  eng_t eng_q[$];
  bit   audit_req = 0;
  bit   vchk = 0;
  int   vch = 0;
  bit   vexp = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] ca, input logic [31:0] cb,
                      input int lat, input bit hang);
    exp_t e;
    eng_t g;
    e.ch = ch; e.ca = ca; e.cb = cb; e.hang = hang;
    g.ca = ca; g.cb = cb; g.lat = lat; g.hang = hang;
    exp_q.push_back(e);
    eng_q.push_back(g);
  endtask

  task automatic pulse_req(input logic [N_CH-1:0] mask);
    @(posedge clk); #1 req = mask;
    @(posedge clk); #1 req = '0;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_if.meas_start && n < 200);
    if (!eng_if.meas_start) chk({name, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle && exp_q.size() == 0 && !vchk) && n < budget);
    chk({name, "_idle"}, {63'd0, idle && exp_q.size() == 0}, 1);
  endtask

  task automatic wait_audit();
    int n;
    n = 0;
    audit_req = 1;
    while (audit_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (audit_req) chk("audit_timeout", 0, 1);
  endtask

  // Behavioural engine: raises busy on start, drops it after lat cycles with the counts.
  initial begin
    eng_t cur;
    int   ecnt;
    bit   ehang;
    ecnt = 0; ehang = 0;
    cur.ca = 0; cur.cb = 0; cur.lat = 0; cur.hang = 0;
    eng_if.meas_busy = 0; eng_if.meas_ca = 0; eng_if.meas_cb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_if.meas_busy = 0; ecnt = 0; ehang = 0;
      end else begin
        if (ehang) begin
          if (eng_if.meas_abort) begin eng_if.meas_busy = 0; ehang = 0; end
        end else if (ecnt > 0) begin
          ecnt--;
          if (ecnt == 0) begin
            eng_if.meas_ca = cur.ca; eng_if.meas_cb = cur.cb; eng_if.meas_busy = 0;
          end
        end
        if (eng_if.meas_start && eng_q.size() > 0) begin
          cur = eng_q.pop_front();
          eng_if.meas_busy = 1;
          eng_if.meas_ca = 32'hDEAD_BEEF; eng_if.meas_cb = 32'h0BAD_F00D;
          ecnt = cur.lat; ehang = cur.hang;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on start/done/err and checks the result bank.
  initial begin
    exp_t       e;
    bit         tracking;
    bit         ws_bad;
    logic [1:0] ws_hold;
    int         cyc;
    tracking = 0; ws_bad = 0; ws_hold = 0; cyc = 0;
    rd_ch = 0;
    forever begin
      @(negedge clk);
      if (rst) tracking = 0;
      if (tracking) begin
        cyc++;
        if (eng_if.wave_sel !== ws_hold) ws_bad = 1;
      end
      if (vchk) begin
        rd_ch = 2'(vch); #1;
        chk("rd_valid_after", {63'd0, rd_valid}, {63'd0, vexp});
        vchk = 0;
      end
      if (audit_req) begin
        for (int c = 0; c < N_CH; c++) begin
          rd_ch = 2'(c); #1;
          chk("rd_valid_cleared", {63'd0, rd_valid}, 0);
        end
        audit_req = 0;
      end
      if (eng_if.meas_start) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else chk("start_ch", {62'd0, eng_if.wave_sel}, exp_q[0].ch);
        tracking = 1; ws_hold = eng_if.wave_sel; ws_bad = 0; cyc = 0;
      end
      if (done != 0) begin
        if (exp_q.size() == 0) chk("unexpected_done", {60'd0, done}, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_ch", {60'd0, done}, 64'd1 << e.ch);
          chk("done_not_hang", {63'd0, e.hang}, 0);
          chk("ws_stable", {63'd0, ws_bad}, 0);
          rd_ch = 2'(e.ch); #1;
          chk("rd_ca", {32'd0, rd_ca}, {32'd0, e.ca});
          chk("rd_cb", {32'd0, rd_cb}, {32'd0, e.cb});
          vchk = 1; vch = e.ch; vexp = 1;
        end
        tracking = 0;
      end
      if (err != 0) begin
        if (exp_q.size() == 0) chk("unexpected_err", {60'd0, err}, 0);
        else begin
          e = exp_q.pop_front();
          chk("err_ch", {60'd0, err}, 64'd1 << e.ch);
          chk("err_expected", {63'd0, e.hang}, 1);
          chk("abort_pulse", {63'd0, eng_if.meas_abort}, 1);
          chk("timeout_cyc", cyc, TIMEOUT_CYC);
          chk("ws_stable_to", {63'd0, ws_bad}, 0);
          vchk = 1; vch = e.ch; vexp = 0;
        end
        tracking = 0;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    bit bad_err, bad_done, bad_idle, bad_start;
    rst = 1; req = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    chk("rst_idle", {63'd0, idle}, 1);
    chk("rst_wave_sel", {62'd0, eng_if.wave_sel}, 0);
    chk("rst_start", {63'd0, eng_if.meas_start}, 0);
    chk("rst_done", {60'd0, done}, 0);
    chk("rst_err", {60'd0, err}, 0);
    chk("rst_abort", {63'd0, eng_if.meas_abort}, 0);
    wait_audit();

    // All four at once with ptr=3: order 0,1,2,3
    push(0, 32'd10, 32'd11, 3, 0);
    push(1, 32'd20, 32'd21, 4, 0);
    push(2, 32'd30, 32'd31, 2, 0);
    push(3, 32'hFFFF_FFFF, 32'h8000_0000, 5, 0);
    pulse_req(4'b1111);
    wait_idle("rr4", 500);

    // Single request on ch2, latency from req to start
    push(2, 32'd1000, 32'd250, 6, 0);
    @(posedge clk); #1 req = 4'b0100;
    @(negedge clk); n = 1;
    @(posedge clk); #1 req = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_if.meas_start && n < 30);
    chk("req_to_start", n, 1 + 1 + SETTLE_CYC + 1);
    wait_idle("single", 200);

    // ch1 re-requested during its own ISSUE: measured twice, second overwrites
    push(1, 32'd111, 32'd222, 4, 0);
    push(1, 32'd333, 32'd444, 3, 0);
    pulse_req(4'b0010);
    wait_start("rereq");
    req = 4'b0010;
    @(posedge clk); #1 req = '0;
    wait_idle("rereq", 300);

`ifdef FMSCHED_TIMEOUT_EN
    // Engine hangs on ch0; watchdog aborts, queued ch3 still served
    push(0, 32'd0, 32'd0, 0, 1);
    push(3, 32'd77, 32'd88, 3, 0);
    pulse_req(4'b0001);
    wait_start("hang");
    pulse_req(4'b1000);
    wait_idle("hang", 3000);

    // Reset during RUN of a long measurement
    push(2, 32'd5, 32'd6, 50, 0);
    pulse_req(4'b0100);
    wait_start("midrst");
    repeat (10) @(negedge clk);
`else
    // Engine hangs with no watchdog: scheduler stays in RUN
    push(0, 32'd0, 32'd0, 0, 1);
    pulse_req(4'b0001);
    wait_start("hang");
    bad_err = 0; bad_done = 0; bad_idle = 0;
    repeat (5000) begin
      @(negedge clk);
      if (err != 0 || eng_if.meas_abort) bad_err = 1;
      if (done != 0) bad_done = 1;
      if (idle) bad_idle = 1;
    end
    chk("stuck_no_err", {63'd0, bad_err}, 0);
    chk("stuck_no_done", {63'd0, bad_done}, 0);
    chk("stuck_not_idle", {63'd0, bad_idle}, 0);
`endif

    // Asynchronous reset mid-measurement
    @(posedge clk); #1 rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_idle", {63'd0, idle}, 1);
    chk("midrst_start", {63'd0, eng_if.meas_start}, 0);
    chk("midrst_done", {60'd0, done}, 0);
    @(posedge clk); #1 rst = 0;
    wait_audit();
    bad_done = 0; bad_start = 0;
    repeat (20) begin
      @(negedge clk);
      if (done != 0) bad_done = 1;
      if (eng_if.meas_start) bad_start = 1;
    end
    chk("post_rst_no_done", {63'd0, bad_done}, 0);
    chk("post_rst_no_start", {63'd0, bad_start}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
